// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit
// Purpose: operand forwarding selects and pipeline stall generation for a
//   5-stage pipeline with a multi-cycle load-use penalty and a multi-cycle,
//   non-pipelined multiplier.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   id_rs, id_rt, id_mul  sources of the ID instruction, ID is a multiply
//   ex_rs, ex_rt          sources of the EX instruction (forwarding targets)
//   ex_rd, ex_regwrite, ex_memread, ex_mul_start  EX destination and flags
//   mem_rd, mem_regwrite  MEM-stage destination and write enable
//   wb_rd, wb_regwrite    WB-stage destination and write enable
//   forward_a, forward_b  2'b10 = from MEM, 2'b01 = from WB, 2'b00 = register file
//   stall                 freeze PC and IF/ID, bubble into ID/EX
//   mul_busy, mul_done    multiply in flight / one-cycle completion pulse
//   dbgState, dbgLoadRd   load-stall FSM state and latched load destination
// Handshake: none; all inputs are sampled level signals from pipeline registers.
module forwarding_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_mul,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_mul_start,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              stall,
  output logic              mul_busy,
  output logic              mul_done,
  output logic [1:0]        dbgState,
  output logic [REG_AW-1:0] dbgLoadRd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LSTALL = 2'd1
  } loadState_t;

  loadState_t        state, nextState;
  logic [1:0]        ldCnt, ldCntNext;
  logic [REG_AW-1:0] ldRd, ldRdNext;
  logic              loadHazard, loadStall, mulStall;
  logic [3:0]        mulCnt;
  logic [REG_AW-1:0] mulRd;

  // MEM has priority over WB because it holds the younger result.
  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) sel = 2'b10;
    else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    forward_a = fwdSel(ex_rs);
    forward_b = fwdSel(ex_rt);
  end

  assign loadHazard = ex_memread & ex_regwrite & (ex_rd != '0) &
                      ((ex_rd == id_rs) | (ex_rd == id_rt));

  // Load-use FSM. The first stall cycle is combinational from IDLE; LSTALL
  // covers the remaining LOAD_LAT-1 cycles and ignores new load hazards.
  always_comb begin
    nextState = state;
    ldCntNext = ldCnt;
    ldRdNext  = ldRd;
    loadStall = 1'b0;
    case (state)
      IDLE: begin
        if (loadHazard) begin
          loadStall = 1'b1;
          if (LOAD_LAT > 1) begin
            nextState = LSTALL;
            ldCntNext = 2'(LOAD_LAT - 1);
            ldRdNext  = ex_rd;
          end
        end
      end
      LSTALL: begin
        loadStall = 1'b1;
        if (ldCnt == 2'd1) begin
          nextState = IDLE;
          ldCntNext = 2'd0;
        end else begin
          ldCntNext = ldCnt - 2'd1;
        end
      end
      default: begin
        nextState = IDLE;
        ldCntNext = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ldCnt <= 2'd0;
      ldRd  <= '0;
    end else begin
      state <= nextState;
      ldCnt <= ldCntNext;
      ldRd  <= ldRdNext;
    end
  end

  // Multiplier occupancy. A start while busy is ignored; the counter runs
  // MUL_LAT busy cycles and the edge that empties it raises mul_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
      mulCnt   <= 4'd0;
      mulRd    <= '0;
    end else begin
      mul_done <= 1'b0;
      if (mul_busy) begin
        if (mulCnt == 4'd1) begin
          mul_busy <= 1'b0;
          mulCnt   <= 4'd0;
          mul_done <= 1'b1;
        end else begin
          mulCnt <= mulCnt - 4'd1;
        end
      end else if (ex_mul_start) begin
        mul_busy <= 1'b1;
        mulCnt   <= 4'(MUL_LAT);
        mulRd    <= ex_rd;
      end
    end
  end

  // mulRd == 0 means the product is discarded, so only the structural
  // hazard on a second multiply remains.
  assign mulStall = mul_busy &
                    (((mulRd != '0) & ((id_rs == mulRd) | (id_rt == mulRd))) | id_mul);

  assign stall     = loadStall | mulStall;
  assign dbgState  = state;
  assign dbgLoadRd = ldRd;

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width in bits (legal 3..6).
REQ-002 Parameter LOAD_LAT, default 1, total load-use stall cycles per hazard (legal 1..4).
REQ-003 Parameter MUL_LAT, default 4, multi-cycle multiply latency in cycles (legal 2..15).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 id_rs, id_rt  input  REG_AW each  source registers of the instruction in ID.
REQ-008 id_mul  input  1  instruction in ID is a multiply.
REQ-009 ex_rs, ex_rt  input  REG_AW each  source registers of the instruction in EX.
REQ-010 ex_rd, ex_regwrite, ex_memread, ex_mul_start  input  REG_AW/1/1/1  EX destination, write enable, load flag, multiply issue.
REQ-011 mem_rd, mem_regwrite  input  REG_AW/1  MEM-stage destination and write enable.
REQ-012 wb_rd, wb_regwrite  input  REG_AW/1  WB-stage destination and write enable.
REQ-013 forward_a, forward_b  output  2 each  operand mux select for ex_rs / ex_rt.
REQ-014 stall  output  1  freeze PC and IF/ID, inject bubble into ID/EX.
REQ-015 mul_busy  output  1  multiply in flight; mul_done  output  1  one-cycle completion pulse.

Function
REQ-016 forward_a SHALL be 2'b10 when mem_regwrite, mem_rd!=0 and mem_rd==ex_rs; otherwise 2'b01 when wb_regwrite, wb_rd!=0 and wb_rd==ex_rs; otherwise 2'b00.
REQ-017 forward_b SHALL follow REQ-016 with ex_rt substituted; 2'b11 SHALL never be driven.
REQ-018 forward_a/forward_b SHALL be combinational (zero latency) and SHALL NOT depend on reset or internal state.
REQ-019 Load hazard: in state IDLE, ex_memread & ex_regwrite & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt) SHALL assert stall in the same cycle.
REQ-020 On a load hazard with LOAD_LAT>1, the FSM SHALL move IDLE->LSTALL, load a counter with LOAD_LAT-1 and latch ex_rd.
REQ-021 In LSTALL, stall SHALL stay 1; counter decrements each cycle; at counter==1 the next state SHALL be IDLE; total stall = LOAD_LAT consecutive cycles.
REQ-022 With LOAD_LAT==1 the FSM SHALL stay in IDLE (single-cycle combinational stall only).
REQ-023 Load hazard checks SHALL be ignored while in LSTALL (no re-trigger, no extension).
REQ-024 Multiply issue: ex_mul_start & ex_rd!=0 while mul_busy==0 SHALL, at the next edge, set mul_busy=1, latch mul_rd=ex_rd, load mul counter with MUL_LAT.
REQ-025 ex_mul_start with ex_rd==0 SHALL still occupy the unit (mul_busy=1) but SHALL generate no RAW stalls.
REQ-026 mul counter SHALL decrement each cycle while busy; on the cycle it reaches 0, mul_busy clears and mul_done SHALL pulse high for exactly one cycle.
REQ-027 While mul_busy, stall SHALL be 1 if mul_rd!=0 and (id_rs==mul_rd or id_rt==mul_rd).
REQ-028 While mul_busy, stall SHALL be 1 if id_mul==1 (structural hazard).
REQ-029 ex_mul_start while mul_busy==1 is illegal upstream; the block SHALL ignore it (no relatch, no counter reload).
REQ-030 stall SHALL be the OR of all active hazard sources; simultaneous load and multiply hazards SHALL NOT alter either counter.
REQ-031 Register 0 SHALL never cause a stall or a forward.

Reset
REQ-032 Asserting reset SHALL immediately force FSM=IDLE, both counters=0, mul_rd=0, mul_busy=0, mul_done=0, and any registered stall source=0.
REQ-033 Reset asserted mid-LSTALL or mid-multiply SHALL abort the operation with no mul_done pulse after release.
REQ-034 After reset deassertion, the first clk edge SHALL evaluate hazards normally.

Verification
REQ-035 mem_regwrite=1, mem_rd=3, wb_regwrite=1, wb_rd=3, ex_rs=3, ex_rt=5 -> forward_a=10, forward_b=00; then mem_rd=0 -> forward_a=01.
REQ-036 LOAD_LAT=1: ex_memread=1, ex_regwrite=1, ex_rd=7, id_rt=7 -> stall=1 that cycle only; ex_rd=0, id_rt=0 -> no stall.
REQ-037 LOAD_LAT=3: same hazard -> stall=1 for exactly 3 consecutive cycles, FSM IDLE->LSTALL->LSTALL->IDLE.
REQ-038 MUL_LAT=4: ex_mul_start, ex_rd=9; id_rs=9 held -> mul_busy high 4 cycles, stall high while busy, mul_done one pulse, stall drops the cycle after.
REQ-039 Multiply in flight, reset pulsed at cycle 2 -> mul_busy=0, stall=0 immediately, no mul_done pulse afterwards.
REQ-040 Multiply busy (mul_rd=4) plus load hazard on id_rs=6 -> stall=1 throughout; mul_done timing unchanged.
